// File: rtl/timers_timer2_capture.sv
// Timer2 capture block: W-bit up-counter on the prescaled tick, capture register
// snapshotted on filtered edge pulses, capture/overflow/overrun flags, irq,
// and a coherent high-byte latch for 8-bit CPU reads.
// Optional build macro TIMERS_TIMER2_PERIOD_EN adds the period measurement
// (prev_cap, wrap counter, subtractor, saturation); without it period_o is 0.
module timers_timer2_capture #(
   parameter int W = 16
) (
   input  logic         timers_timer2_clock_i_b,
   input  logic         timers_timer2_reset_i,
   input  logic         timers_timer2_cnt_enable_i,
   input  logic         timers_sfr_tcon2_tr2_i,
   input  logic         timers_timer2_pdfoutput_i,
   input  logic         timers_sfr_cap2_clr_i,
   input  logic         timers_sfr_cap2_rdl_i,
   output logic [W-1:0] timers_timer2_count_o,
   output logic [W-1:0] timers_timer2_cap_o,
   output logic [7:0]   timers_timer2_cap_hi_o,
   output logic [W-1:0] timers_timer2_period_o,
   output logic         timers_timer2_capf_o,
   output logic         timers_timer2_ovf_o,
   output logic         timers_timer2_overrun_o,
   output logic         timers_timer2_irq_o,
   output logic [1:0]   timers_timer2_state_o
);

   typedef enum logic [1:0] {
      STOP = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] count;
   logic [W-1:0] cap;
   logic [7:0]   cap_hi;
   logic [W-1:0] period;
   logic         capf;
   logic         ovf;
   logic         overrun;
   logic         inc;
   logic         wrap;
   logic         cap_ev;

   // Counting and capture are gated by the live run bit, so dropping tr2 stops
   // both in the same cycle the FSM heads back to STOP.
   assign inc    = timers_sfr_tcon2_tr2_i & timers_timer2_cnt_enable_i;
   assign wrap   = inc & (&count);
   assign cap_ev = timers_sfr_tcon2_tr2_i & timers_timer2_pdfoutput_i;

   // State register.
   always_ff @(posedge timers_timer2_clock_i_b) begin
      if (timers_timer2_reset_i) state <= STOP;
      else                       state <= state_nxt;
   end

   // Next state: tr2 low forces STOP from anywhere; ARM waits for a first capture.
   always_comb begin
      state_nxt = state;
      if (!timers_sfr_tcon2_tr2_i) begin
         state_nxt = STOP;
      end else begin
         case (state)
            STOP:    state_nxt = ARM;
            ARM:     if (cap_ev) state_nxt = MEAS;
            MEAS:    state_nxt = MEAS;
            default: state_nxt = STOP;
         endcase
      end
   end

   // Free-running counter, advanced only on the prescaled tick while running.
   always_ff @(posedge timers_timer2_clock_i_b) begin
      if (timers_timer2_reset_i) count <= '0;
      else if (inc)              count <= count + ONE;
   end

   // Flags: set beats clear for capf and ovf; clear beats set for overrun.
   always_ff @(posedge timers_timer2_clock_i_b) begin
      if (timers_timer2_reset_i) begin
         capf    <= 1'b0;
         ovf     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (cap_ev)                     capf <= 1'b1;
         else if (timers_sfr_cap2_clr_i) capf <= 1'b0;

         if (wrap)                       ovf <= 1'b1;
         else if (timers_sfr_cap2_clr_i) ovf <= 1'b0;

         if (timers_sfr_cap2_clr_i)      overrun <= 1'b0;
         else if (cap_ev && capf)        overrun <= 1'b1;
      end
   end

   // Capture register and read latch; the latch always takes the pre-edge cap.
   always_ff @(posedge timers_timer2_clock_i_b) begin
      if (timers_timer2_reset_i) begin
         cap    <= '0;
         cap_hi <= '0;
      end else begin
         if (cap_ev)                cap    <= count;
         if (timers_sfr_cap2_rdl_i) cap_hi <= cap[W-1:W-8];
      end
   end

`ifdef TIMERS_TIMER2_PERIOD_EN
   logic [W-1:0] prev_cap;
   logic [W-1:0] diff;
   logic [1:0]   wc;
   logic [1:0]   wc_nxt;
   logic         in_range;

   // Difference is trusted only with no wrap, or one wrap that landed below prev_cap.
   // A capture coinciding with a wrap restarts the wrap count at 1: the captured
   // value is pre-wrap, so that wrap belongs to the next interval.
   always_comb begin
      diff     = count - prev_cap;
      in_range = (wc == 2'd0) || ((wc == 2'd1) && (count < prev_cap));
      wc_nxt   = wc;
      if (cap_ev)                   wc_nxt = {1'b0, wrap};
      else if (wrap && wc != 2'd3)  wc_nxt = wc + 2'd1;
   end

   // Period measurement state; period updates only on captures made in MEAS.
   always_ff @(posedge timers_timer2_clock_i_b) begin
      if (timers_timer2_reset_i) begin
         prev_cap <= '0;
         wc       <= 2'd0;
         period   <= '0;
      end else begin
         wc <= wc_nxt;
         if (cap_ev) begin
            prev_cap <= count;
            if (state == MEAS) period <= in_range ? diff : '1;
         end
      end
   end
`else
   assign period = '0;
`endif

   assign timers_timer2_count_o   = count;
   assign timers_timer2_cap_o     = cap;
   assign timers_timer2_cap_hi_o  = cap_hi;
   assign timers_timer2_period_o  = period;
   assign timers_timer2_capf_o    = capf;
   assign timers_timer2_ovf_o     = ovf;
   assign timers_timer2_overrun_o = overrun;
   assign timers_timer2_irq_o     = capf | ovf;
   assign timers_timer2_state_o   = state;

endmodule

// File: tb/tb_timers_timer2_capture.sv
// Bench for timers_timer2_capture, built with W=12 so counter wraps are reachable
// in a few thousand cycles. Drivers push expected output values into a queue
// stamped with the cycle they apply to; a negedge monitor pops and compares.
module tb_timers_timer2_capture;

   localparam int W = 12;
   localparam logic [W-1:0] ALL1 = '1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cen = 1'b1;
   logic         tr2 = 1'b1;
   logic         pdf = 1'b1;
   logic         clr = 1'b0;
   logic         rdl = 1'b0;
   logic [W-1:0] count, cap, period;
   logic [7:0]   cap_hi;
   logic         capf, ovf, overrun, irq;
   logic [1:0]   state_dbg;

   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   logic [W-1:0] mc = '0;     // model of the live counter

   logic [W-1:0] exp_q[$];
   int           sel_q[$];
   int           at_q[$];

   timers_timer2_capture #(.W(W)) dut (
      .timers_timer2_clock_i_b    (clk),
      .timers_timer2_reset_i      (rst),
      .timers_timer2_cnt_enable_i (cen),
      .timers_sfr_tcon2_tr2_i     (tr2),
      .timers_timer2_pdfoutput_i  (pdf),
      .timers_sfr_cap2_clr_i      (clr),
      .timers_sfr_cap2_rdl_i      (rdl),
      .timers_timer2_count_o      (count),
      .timers_timer2_cap_o        (cap),
      .timers_timer2_cap_hi_o     (cap_hi),
      .timers_timer2_period_o     (period),
      .timers_timer2_capf_o       (capf),
      .timers_timer2_ovf_o        (ovf),
      .timers_timer2_overrun_o    (overrun),
      .timers_timer2_irq_o        (irq),
      .timers_timer2_state_o      (state_dbg)
   );

   // Clock and cycle stamp.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int S_COUNT = 0, S_CAP = 1, S_CAPHI = 2, S_PERIOD = 3, S_CAPF = 4,
                  S_OVF = 5, S_OVR = 6, S_IRQ = 7, S_STATE = 8;

   function automatic logic [W-1:0] pick(input int s);
      case (s)
         S_COUNT:  pick = count;
         S_CAP:    pick = cap;
         S_CAPHI:  pick = {{(W-8){1'b0}}, cap_hi};
         S_PERIOD: pick = period;
         S_CAPF:   pick = {{(W-1){1'b0}}, capf};
         S_OVF:    pick = {{(W-1){1'b0}}, ovf};
         S_OVR:    pick = {{(W-1){1'b0}}, overrun};
         S_IRQ:    pick = {{(W-1){1'b0}}, irq};
         S_STATE:  pick = {{(W-2){1'b0}}, state_dbg};
         default:  pick = '0;
      endcase
   endfunction

   function automatic string nm(input int s);
      case (s)
         S_COUNT:  nm = "count";
         S_CAP:    nm = "cap";
         S_CAPHI:  nm = "cap_hi";
         S_PERIOD: nm = "period";
         S_CAPF:   nm = "capf";
         S_OVF:    nm = "ovf";
         S_OVR:    nm = "overrun";
         S_IRQ:    nm = "irq";
         S_STATE:  nm = "state";
         default:  nm = "unknown";
      endcase
   endfunction

   // Period is only produced when the measurement option is compiled in.
   function automatic logic [W-1:0] per(input logic [W-1:0] v);
`ifdef TIMERS_TIMER2_PERIOD_EN
      per = v;
`else
      per = '0;
`endif
   endfunction

   // Expectation for the outputs seen after the coming clock edge.
   task automatic want(input int s, input logic [W-1:0] v);
      sel_q.push_back(s);
      exp_q.push_back(v);
      at_q.push_back(cyc + 1);
   endtask

   task automatic want_flags(input logic f_capf, input logic f_ovf, input logic f_ovr);
      want(S_CAPF, {{(W-1){1'b0}}, f_capf});
      want(S_OVF,  {{(W-1){1'b0}}, f_ovf});
      want(S_OVR,  {{(W-1){1'b0}}, f_ovr});
      want(S_IRQ,  {{(W-1){1'b0}}, f_capf | f_ovf});
   endtask

   // One clock: update the counter model, advance, drop one-cycle strobes.
   task automatic step();
      if (rst)             mc = '0;
      else if (tr2 && cen) mc = mc + 1'b1;
      @(posedge clk);
      #1;
      pdf = 1'b0;
      clr = 1'b0;
      rdl = 1'b0;
   endtask

   task automatic advance_to(input logic [W-1:0] target);
      while (mc != target) step();
   endtask

   // Monitor: compare every expectation due at this cycle.
   int           m_sel, m_at;
   logic [W-1:0] m_exp, m_got;
   always @(negedge clk) begin
      while (at_q.size() > 0 && at_q[0] <= cyc) begin
         m_sel = sel_q.pop_front();
         m_exp = exp_q.pop_front();
         m_at  = at_q.pop_front();
         m_got = pick(m_sel);
         total = total + 1;
         if (m_at != cyc) begin
            bad = bad + 1;
            $display("FAIL %s: check due at cycle %0d seen at cycle %0d", nm(m_sel), m_at, cyc);
         end else if (m_got !== m_exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm(m_sel), m_got, m_exp, cyc);
         end
      end
   end

   initial begin
      // 1: reset with run and a pulse present; nothing is captured.
      want(S_COUNT, '0); want(S_CAP, '0); want(S_CAPHI, '0); want(S_PERIOD, '0);
      want_flags(1'b0, 1'b0, 1'b0); want(S_STATE, 12'd0);
      step();
      pdf = 1'b1;
      want(S_CAPF, '0); want(S_STATE, 12'd0); want(S_COUNT, '0);
      step();
      rst = 1'b0; tr2 = 1'b0;
      want(S_COUNT, '0); want(S_STATE, 12'd0);
      step();

      // 2: two captures 0x100 apart, second without clear.
      tr2 = 1'b1;
      want(S_STATE, 12'd1);
      step();
      advance_to(12'h010);
      pdf = 1'b1;
      want(S_CAP, 12'h010); want(S_STATE, 12'd2); want_flags(1'b1, 1'b0, 1'b0);
      step();
      advance_to(12'h110);
      pdf = 1'b1;
      want(S_CAP, 12'h110); want(S_PERIOD, per(12'h100)); want_flags(1'b1, 1'b0, 1'b1);
      step();
      clr = 1'b1;
      want_flags(1'b0, 1'b0, 1'b0);
      step();

      // 3: captures straddling one wrap.
      advance_to(12'hFF0);
      pdf = 1'b1;
      want(S_CAP, 12'hFF0); want_flags(1'b1, 1'b0, 1'b0);
      step();
      advance_to(ALL1);
      want(S_COUNT, '0); want(S_OVF, 12'd1); want(S_IRQ, 12'd1);
      step();
      advance_to(12'h020);
      pdf = 1'b1;
      want(S_CAP, 12'h020); want(S_PERIOD, per(12'h030)); want_flags(1'b1, 1'b1, 1'b1);
      step();
      clr = 1'b1;
      want_flags(1'b0, 1'b0, 1'b0);
      step();

      // 4: saturation after two wraps, valid single wrap, and one wrap past prev_cap.
      advance_to(12'h100);
      pdf = 1'b1;
      want(S_PERIOD, per(12'h0E0));
      step();
      advance_to(ALL1); step();
      advance_to(ALL1); step();
      advance_to(12'h200);
      pdf = 1'b1;
      want(S_CAP, 12'h200); want(S_PERIOD, per(ALL1));
      step();
      advance_to(12'h100);
      pdf = 1'b1;
      want(S_PERIOD, per(12'hF00));
      step();
      advance_to(ALL1); step();
      advance_to(12'h150);
      pdf = 1'b1;
      want(S_CAP, 12'h150); want(S_PERIOD, per(ALL1));
      step();
      clr = 1'b1;
      step();

      // 5: run dropped between captures; ARM needs a fresh first capture.
      rst = 1'b1;
      want(S_COUNT, '0); want(S_PERIOD, '0); want(S_STATE, 12'd0);
      step();
      rst = 1'b0;
      step();
      advance_to(12'h020);
      pdf = 1'b1;
      want(S_PERIOD, '0);
      step();
      advance_to(12'h040);
      pdf = 1'b1;
      want(S_PERIOD, per(12'h020)); want(S_STATE, 12'd2);
      step();
      tr2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) pdf = 1'b1;
         want(S_COUNT, 12'h041); want(S_STATE, 12'd0); want(S_CAP, 12'h040);
         step();
      end
      tr2 = 1'b1;
      want(S_STATE, 12'd1); want(S_COUNT, 12'h042);
      step();
      advance_to(12'h080);
      pdf = 1'b1;
      want(S_CAP, 12'h080); want(S_PERIOD, per(12'h020)); want(S_STATE, 12'd2);
      step();
      advance_to(12'h090);
      pdf = 1'b1;
      want(S_PERIOD, per(12'h010));
      step();

      // 6: read latch against a same-cycle capture, then clear racing a capture.
      advance_to(12'h2AB);
      pdf = 1'b1;
      want(S_CAP, 12'h2AB);
      step();
      advance_to(12'h340);
      pdf = 1'b1; rdl = 1'b1;
      want(S_CAPHI, 12'h02A); want(S_CAP, 12'h340);
      step();
      rdl = 1'b1;
      want(S_CAPHI, 12'h034);
      step();
      for (int i = 0; i < 3; i++) begin
         want(S_CAPHI, 12'h034);
         step();
      end
      advance_to(12'h350);
      pdf = 1'b1; clr = 1'b1;
      want(S_CAP, 12'h350); want(S_PERIOD, per(12'h010)); want_flags(1'b1, 1'b0, 1'b0);
      step();
      advance_to(ALL1);
      clr = 1'b1;
      want_flags(1'b0, 1'b1, 1'b0);
      step();
      clr = 1'b1;
      want_flags(1'b0, 1'b0, 1'b0);
      step();

      step();
      step();
      if (at_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain: %0d checks left unseen, want 0", at_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timers_timer2_capture.md
Name: timers_timer2_capture

Overview:
- Downstream consumer of the Timer2 PHT digital-filter/edge-detector stage.
- Runs a W-bit up-counter on the prescaled tick. On each single-cycle filtered edge pulse, it snapshots the counter into a capture register and, in the measuring state, computes the period since the previous capture.
- Drives capture, overflow and overrun flags plus an interrupt request to the SFR/interrupt logic.
- Provides a coherent high-byte latch for 8-bit CPU reads.

Parameters:
- W, 16: counter, capture and period width (min 9).

Ports:
- timers_timer2_clock_i_b, input, 1: block clock.
- timers_timer2_reset_i, input, 1: synchronous, active-high reset.
- timers_timer2_cnt_enable_i, input, 1: prescaled count tick, one cycle wide.
- timers_sfr_tcon2_tr2_i, input, 1: run control; 1 = counting and capturing enabled.
- timers_timer2_pdfoutput_i, input, 1: filtered edge pulse from the PDF stage.
- timers_sfr_cap2_clr_i, input, 1: one-cycle strobe that clears capf, ovf and overrun.
- timers_sfr_cap2_rdl_i, input, 1: one-cycle strobe marking a CPU read of the capture low byte.
- timers_timer2_count_o, output, W: live counter value.
- timers_timer2_cap_o, output, W: last captured count.
- timers_timer2_cap_hi_o, output, 8: cap[W-1:W-8] latched at the low-byte read.
- timers_timer2_period_o, output, W: cycles between the last two captures.
- timers_timer2_capf_o, output, 1: capture flag.
- timers_timer2_ovf_o, output, 1: counter wrap flag.
- timers_timer2_overrun_o, output, 1: capture occurred while capf was still set.
- timers_timer2_irq_o, output, 1: capf OR ovf, taken from register outputs.

Behaviour:
- Reset: every register and output = 0; state = STOP; wrap counter = 0. Reset asserted mid-operation takes effect at the next clock edge and discards any capture pulse in that cycle.
- States:
  - STOP: tr2=0. Counter holds its value, pulses are ignored, flags hold.
  - ARM: running, no valid previous capture yet.
  - MEAS: running with a valid previous capture.
- Transitions:
  - STOP→ARM when tr2=1.
  - ARM→MEAS on the first capture pulse.
  - Any state→STOP when tr2=0, in that same cycle.
  - Re-entering ARM after STOP always requires a fresh first capture before a period is computed.
- Counting: when tr2 & cnt_enable, count <= count+1 modulo 2^W.
  - Wrap from all-ones to 0 sets ovf in the same edge.
  - The wrap counter (2 bits, saturating) increments on each wrap and is cleared on every capture.
- Capture: on pdfoutput_i=1 while tr2=1:
  - cap <= count as sampled before that cycle's increment.
  - capf <= 1, visible one cycle after the pulse.
  - If capf was already 1 at that edge: overrun <= 1 and cap is still overwritten.
- Period, MEAS capture only: D = count - prev_cap modulo 2^W.
  - period <= D if the wrap counter is 0, or if it is 1 and count < prev_cap.
  - Otherwise period <= all-ones (saturated).
  - prev_cap <= count on every capture, in both ARM and MEAS.
- Simultaneous events:
  - clr strobe together with capture: capf=1, ovf and overrun cleared; set wins over clear for capf.
  - clr together with wrap: ovf=1.
  - Capture together with wrap: cap takes the pre-increment value and the wrap counter is cleared after accounting for this wrap (the period uses the pre-wrap count).
- Read latch: on rdl strobe, cap_hi <= cap[W-1:W-8].
  - A capture in the same cycle does not affect the latched value; the latch takes the old cap.
  - cap_hi is stable until the next rdl.
- irq_o = capf | ovf, combinational from flops with no extra latency.

Optional Feature:
- TIMERS_TIMER2_PERIOD_EN defined: prev_cap, the wrap counter, the subtractor and the saturation logic are present, and period_o behaves as specified above.
- Not defined: that logic is removed, period_o is tied to 0, and ARM/MEAS behave identically except for the state encoding. Capture, flags and irq are unchanged.

Test Plan:
1. Reset with tr2=1 and a pulse present → all outputs 0, state STOP for that cycle; the pulse is not captured.
2. tr2=1, cnt_enable every cycle; pulses when count=0x0010 and count=0x0110 → cap=0x0110, period=0x0100, capf=1 one cycle after each pulse. Second pulse without clr → overrun=1.
3. Counter preset near wrap: pulses at count=0xFFF0 then count=0x0020 (one wrap) → period=0x0030, ovf=1, irq=1. A single clr → capf/ovf/overrun=0, irq=0.
4. Pulses at 0x0100 and 0x0200 with two wraps between them → period=0xFFFF. Pulse at 0x0100, one wrap, pulse at 0x0150 → period=0xFFFF.
5. tr2 dropped between pulses: pulse at 0x0040, tr2=0 for 5 cycles (count holds, a pulse is ignored), tr2=1, pulse at 0x0080 → cap=0x0080, period unchanged (ARM), next pulse at 0x0090 → period=0x0010.
6. rdl strobe with cap=0x12AB while a capture of 0x3400 lands in the same cycle → cap_hi=0x12, cap=0x3400; the next rdl gives cap_hi=0x34. clr and a capture in the same cycle → capf=1, overrun=0.
